fetch_decode_stage: RTL
=======================

// Module: fetch_decode_stage
// PURPOSE
//  IF stage plus IF/ID pipeline register of the 5-stage RV32I core. Owns the PC and the PC+4/branch-target select.
//  Presents pc_F to the instruction memory, which reads combinationally in the same cycle, and registers the returned word into ID.
//  Consumes Stall_F, Stall_D and Flush_D from hazard_detection_unit, and PCSrcE/PCTargetE from EX.
//  Keeps saturating stall and flush event counters for performance debug.
// PARAMETERS
//  XLEN      32             datapath/PC width
//  RESET_PC  32'h0000_0000  PC value loaded at reset
//  NOP_INSTR 32'h0000_0013  word inserted into ID on reset/flush (addi x0,x0,0)
//  CNT_W     16             width of stall/flush counters
// PORTS
//  clk         in   1      single core clock, rising edge
//  rst_n       in   1      asynchronous, active-low reset
//  Stall_F     in   1      hold PC
//  Stall_D     in   1      hold IF/ID register
//  Flush_D     in   1      clear IF/ID register to bubble
//  PCSrcE      in   1      redirect taken (branch/jump resolved in EX)
//  PCTargetE   in   XLEN   redirect target address
//  instr_F     in   32     instruction word from imem at pc_F (same cycle)
//  pc_F        out  XLEN   current fetch address to imem
//  instr_D     out  32     registered instruction for decode
//  pc_D        out  XLEN   PC of instr_D
//  pc_plus4_D  out  XLEN   pc_D+4 (link value for JAL/JALR)
//  valid_D     out  1      1 = instr_D is real; 0 = bubble
//  stall_cnt   out  CNT_W  cycles with Stall_F=1 and PCSrcE=0, saturating
//  flush_cnt   out  CNT_W  cycles with Flush_D=1, saturating
// BEHAVIOUR
//  Reset (async assert, sync release):
//   - pc_F=RESET_PC; instr_D=NOP_INSTR; pc_D=0; pc_plus4_D=0; valid_D=0; counters=0.
//   - First fetch happens at RESET_PC in the first cycle after release.
//  PC update each edge, in priority order:
//   - PCSrcE=1 -> pc_F<=PCTargetE. PCSrcE wins over Stall_F.
//   - else Stall_F=1 -> pc_F holds.
//   - else pc_F<=pc_F+4, mod 2^XLEN. 32'hFFFF_FFFC wraps to 0 with no flag.
//  IF/ID update each edge, in priority order:
//   - Flush_D=1 -> instr_D=NOP_INSTR, valid_D=0, pc_D/pc_plus4_D=0. Flush_D wins over Stall_D.
//   - else Stall_D=1 -> all IF/ID fields hold.
//   - else instr_D<=instr_F, pc_D<=pc_F, pc_plus4_D<=pc_F+4, valid_D<=1.
//  Latency:
//   - A fetch at pc_F appears on instr_D one edge later.
//   - After PCSrcE, the target's instruction reaches instr_D two edges later. The wrong-path word is flushed by Flush_D in the same cycle.
//  Simultaneous Stall_F=1 and PCSrcE=1 (treated as legal):
//   - PC takes the target. stall_cnt does not count that cycle.
//  Stall_D=1 with Stall_F=0 (not expected):
//   - PC advances; IF/ID holds, so the fetched word is dropped. No assertion in RTL.
//  Counters increment by 1 per qualifying cycle and stick at all-ones.
//  Reset mid-operation: all state returns to reset values immediately, regardless of stall/flush inputs.
//  No internal FSM beyond the registers. All outputs are registered except pc_F, which is the PC register itself.
// STRUCTURE
//  riscv_pkg (shared): XLEN, RESET_PC default, NOP_INSTR, CNT_W default. Already used by decode/EX stages.
//  Sub-module pipe_reg_en_clr #(W, RST_VAL, CLR_VAL):
//   - async active-low reset; en=~stall; clr=flush; clr has priority over en.
//   - Instantiated once for the PC (clr tied 0; redirect is handled by a next-PC mux) and once for the packed IF/ID bundle.
//   - Reused later for the ID/EX register with Flush_E.
//  Next-PC mux and both +4 adders are inline combinational logic. Counters are inline.
// TESTING
//  T1 Reset with imem returning addr-tagged words:
//     rst_n low 3 cycles then high -> pc_F=0,4,8,...; instr_D=word@0 one edge after release; valid_D=0 until then.
//  T2 Stall:
//     Stall_F=Stall_D=1 for 2 cycles at pc_F=0x10 -> pc_F stays 0x10, instr_D/pc_D=0x0C frozen, stall_cnt+=2.
//     Release -> pc_F=0x14.
//  T3 Redirect:
//     PCSrcE=1, Flush_D=1, PCTargetE=0x100 at pc_F=0x20 -> next pc_F=0x100, instr_D=0x13, valid_D=0, flush_cnt=1.
//     Next edge -> instr_D=word@0x100, pc_plus4_D=0x104.
//  T4 Conflict:
//     Stall_F=1, Stall_D=1, Flush_D=1, PCSrcE=1, PCTargetE=0x40 -> pc_F=0x40, IF/ID=bubble, stall_cnt unchanged.
//  T5 Wrap:
//     Run with RESET_PC=32'hFFFF_FFF8 -> pc_F sequence FFFF_FFF8, FFFF_FFFC, 0000_0000; pc_plus4_D of FFFF_FFFC is 0.
//  T6 Mid-run reset and saturation:
//     CNT_W=4; hold stall 20 cycles -> stall_cnt=0xF.
//     Assert rst_n mid-stall -> all outputs at reset values asynchronously, before the next clk edge.

Source files
------------

// File: rtl/fetch_decode_stage_pkg.sv
// rtl/fetch_decode_stage_pkg.sv - shared constants and types for the fetch/decode stage
//
// Purpose : default datapath width, reset PC, bubble instruction and counter
//           width used by the IF stage and the IF/ID register; next-PC select
//           enumeration.
// Ports   : none (package).
package fetch_decode_stage_pkg;

  localparam int          XLEN_DEFAULT      = 32;
  localparam logic [31:0] RESET_PC_DEFAULT  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;  // addi x0,x0,0
  localparam int          CNT_W_DEFAULT     = 16;

  // Source of the next PC value, in falling priority: redirect, hold, sequential.
  typedef enum logic [1:0] {
    PC_SEQ      = 2'd0,
    PC_HOLD     = 2'd1,
    PC_REDIRECT = 2'd2
  } pc_sel_e;

endpackage

// File: rtl/fetch_decode_stage_if.sv
// rtl/fetch_decode_stage_if.sv - hazard, imem and IF/ID signal bundle of the fetch/decode stage
//
// Purpose : groups every non-clock signal of the stage. The master side is the
//           surrounding core (hazard unit, EX redirect, imem, decode); the
//           slave side is fetch_decode_stage.
// Signals : Stall_F, Stall_D, Flush_D, PCSrcE, PCTargetE, instr_F  (to stage)
//           pc_F, instr_D, pc_D, pc_plus4_D, valid_D,
//           stall_cnt, flush_cnt                                 (from stage)
interface fetch_decode_stage_if #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
);

  logic             Stall_F;
  logic             Stall_D;
  logic             Flush_D;
  logic             PCSrcE;
  logic [XLEN-1:0]  PCTargetE;
  logic [31:0]      instr_F;

  logic [XLEN-1:0]  pc_F;
  logic [31:0]      instr_D;
  logic [XLEN-1:0]  pc_D;
  logic [XLEN-1:0]  pc_plus4_D;
  logic             valid_D;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output Stall_F, Stall_D, Flush_D, PCSrcE, PCTargetE, instr_F,
    input  pc_F, instr_D, pc_D, pc_plus4_D, valid_D, stall_cnt, flush_cnt
  );

  modport slave (
    input  Stall_F, Stall_D, Flush_D, PCSrcE, PCTargetE, instr_F,
    output pc_F, instr_D, pc_D, pc_plus4_D, valid_D, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/fetch_decode_stage_pipe_reg.sv
// rtl/fetch_decode_stage_pipe_reg.sv - pipeline register with enable and clear
//
// Purpose : W-bit register, asynchronous active-low reset to RST_VAL,
//           synchronous clear to CLR_VAL (priority over enable), load on en.
// Ports   : clk, rst_n, en (load, i.e. ~stall), clr (flush), d, q.
module fetch_decode_stage_pipe_reg #(
  parameter int           W       = 32,
  parameter logic [W-1:0] RST_VAL = '0,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// rtl/fetch_decode_stage.sv - RV32I IF stage and IF/ID pipeline register
//
// Purpose : owns the PC and its next-PC select (redirect / hold / +4), presents
//           pc_F to a combinational imem, registers the fetched word into ID,
//           and keeps saturating stall and flush counters.
// Ports   : clk    - core clock, rising edge
//           rst_n  - asynchronous active-low reset
//           bus    - fetch_decode_stage_if.slave (hazard controls, redirect,
//                    imem word in; pc_F, IF/ID fields, counters out)
module fetch_decode_stage
  import fetch_decode_stage_pkg::*;
#(
  parameter int              XLEN      = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC  = XLEN'(RESET_PC_DEFAULT),
  parameter logic [31:0]     NOP_INSTR = NOP_INSTR_DEFAULT,
  parameter int              CNT_W     = CNT_W_DEFAULT
) (
  input  logic                clk,
  input  logic                rst_n,
  fetch_decode_stage_if.slave bus
);

  // IF/ID bundle layout: {valid, pc_plus4, pc, instr}
  localparam int              ID_W      = 1 + 2 * XLEN + 32;
  localparam logic [ID_W-1:0] ID_BUBBLE = {1'b0, {(2 * XLEN){1'b0}}, NOP_INSTR};

  pc_sel_e         pc_sel;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_plus4_f;
  logic [ID_W-1:0] id_d;
  logic [ID_W-1:0] id_q;
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // A resolved redirect from EX beats a hazard stall: the stalled wrong-path
  // fetch is being discarded anyway.
  always_comb begin
    pc_sel = PC_SEQ;
    if (bus.PCSrcE) begin
      pc_sel = PC_REDIRECT;
    end else if (bus.Stall_F) begin
      pc_sel = PC_HOLD;
    end
  end

  assign pc_plus4_f = pc_q + XLEN'(4);  // wraps mod 2^XLEN

  always_comb begin
    pc_next = pc_plus4_f;
    case (pc_sel)
      PC_REDIRECT: pc_next = bus.PCTargetE;
      PC_HOLD:     pc_next = pc_q;
      default:     pc_next = pc_plus4_f;
    endcase
  end

  // Redirect is handled by the mux above, so the PC register never clears.
  fetch_decode_stage_pipe_reg #(
    .W       (XLEN),
    .RST_VAL (RESET_PC),
    .CLR_VAL (RESET_PC)
  ) u_pc_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pc_sel != PC_HOLD),
    .clr   (1'b0),
    .d     (pc_next),
    .q     (pc_q)
  );

  assign id_d = {1'b1, pc_plus4_f, pc_q, bus.instr_F};

  fetch_decode_stage_pipe_reg #(
    .W       (ID_W),
    .RST_VAL (ID_BUBBLE),
    .CLR_VAL (ID_BUBBLE)
  ) u_ifid_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (~bus.Stall_D),
    .clr   (bus.Flush_D),
    .d     (id_d),
    .q     (id_q)
  );

  // A stall cycle that coincides with a redirect is not a lost fetch slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (bus.Stall_F && !bus.PCSrcE && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      end
      if (bus.Flush_D && (flush_cnt_q != {CNT_W{1'b1}})) begin
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.pc_F       = pc_q;
  assign bus.valid_D    = id_q[ID_W-1];
  assign bus.pc_plus4_D = id_q[ID_W-2 -: XLEN];
  assign bus.pc_D       = id_q[32 +: XLEN];
  assign bus.instr_D    = id_q[31:0];
  assign bus.stall_cnt  = stall_cnt_q;
  assign bus.flush_cnt  = flush_cnt_q;

endmodule
